// File: rtl/pueo_trig_stamper.sv
// Trigger admission and timestamp stage (aclk domain).
// Admits requests under holdoff / pending limits and stamps them.
module pueo_trig_stamper #(
    parameter int unsigned TIME_BITS   = 16,
    parameter int unsigned LOOKBACK    = 512,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic                 aclk_i,
    input  logic                 aresetn_i,
    input  logic                 run_rst_i,
    input  logic                 run_stop_i,
    input  logic [TIME_BITS-1:0] holdoff_i,
    input  logic                 trig_req_i,
    input  logic                 ev_done_i,
    output logic [TIME_BITS-1:0] trig_time_o,
    output logic                 trig_valid_o,
    output logic [15:0]          trig_num_o,
    output logic [3:0]           pending_o,
    output logic [15:0]          drop_cnt_o,
    output logic                 running_o,
    output logic                 underflow_o
);

    localparam logic [TIME_BITS-1:0] LB   = TIME_BITS'(LOOKBACK);
    localparam logic [3:0]           MAXP = 4'(MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD
    } state_t;

    logic rst_meta_q;
    logic rst_sync_q;

    state_t               state_q, state_d;
    logic [TIME_BITS-1:0] tnow_q, tnow_d;
    logic [TIME_BITS-1:0] hold_q, hold_d;
    logic [TIME_BITS-1:0] hcnt_q, hcnt_d;
    logic [TIME_BITS-1:0] time_q, time_d;
    logic                 valid_q, valid_d;
    logic [15:0]          evcnt_q, evcnt_d;
    logic [15:0]          num_q, num_d;
    logic [3:0]           pend_q, pend_d;
    logic [15:0]          drop_q, drop_d;
    logic                 uf_q, uf_d;
    logic                 accept;
    logic                 drop;

    // Reset: asserts immediately, releases two edges after aresetn_i rises.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Run control, admission decision, counters and pending bookkeeping.
    always_comb begin
        state_d = state_q;
        tnow_d  = tnow_q;
        hold_d  = hold_q;
        hcnt_d  = hcnt_q;
        time_d  = time_q;
        valid_d = 1'b0;
        evcnt_d = evcnt_q;
        num_d   = num_q;
        pend_d  = pend_q;
        drop_d  = drop_q;
        uf_d    = uf_q;
        accept  = 1'b0;
        drop    = 1'b0;

        if (run_stop_i) begin
            state_d = S_IDLE;
            tnow_d  = '0;
        end else if (run_rst_i) begin
            // This cycle counts as tnow=0, so the next one is 1.
            state_d = S_RUN;
            tnow_d  = TIME_BITS'(1);
            hold_d  = holdoff_i;
            pend_d  = '0;
            drop_d  = '0;
            evcnt_d = '0;
            num_d   = '0;
            uf_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    tnow_d = '0;
                end
                S_RUN: begin
                    tnow_d = tnow_q + 1'b1;
                    if (trig_req_i) begin
                        if (pend_q < MAXP) accept = 1'b1;
                        else               drop   = 1'b1;
                    end
                end
                S_HOLD: begin
                    tnow_d = tnow_q + 1'b1;
                    drop   = trig_req_i;
                    if (hcnt_q == '0) state_d = S_RUN;
                    else              hcnt_d  = hcnt_q - 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    tnow_d  = '0;
                end
            endcase

            if (accept) begin
                time_d  = tnow_q - LB;
                valid_d = 1'b1;
                num_d   = evcnt_q;
                evcnt_d = evcnt_q + 16'd1;
                if (hold_q != '0) begin
                    state_d = S_HOLD;
                    hcnt_d  = hold_q - 1'b1;
                end
            end

            if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end

        // A restart wipes the count; a stop still lets readouts retire.
        if (run_stop_i || !run_rst_i) begin
            if (accept && !ev_done_i) begin
                pend_d = pend_q + 4'd1;
            end else if (ev_done_i && !accept) begin
                if (pend_q == '0) uf_d   = 1'b1;
                else              pend_d = pend_q - 4'd1;
            end
        end
    end

    // State and datapath registers on the synchronised reset.
    always_ff @(posedge aclk_i or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= S_IDLE;
            tnow_q  <= '0;
            hold_q  <= '0;
            hcnt_q  <= '0;
            time_q  <= '0;
            valid_q <= 1'b0;
            evcnt_q <= '0;
            num_q   <= '0;
            pend_q  <= '0;
            drop_q  <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tnow_q  <= tnow_d;
            hold_q  <= hold_d;
            hcnt_q  <= hcnt_d;
            time_q  <= time_d;
            valid_q <= valid_d;
            evcnt_q <= evcnt_d;
            num_q   <= num_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            uf_q    <= uf_d;
        end
    end

    assign trig_time_o  = time_q;
    assign trig_valid_o = valid_q;
    assign trig_num_o   = num_q;
    assign pending_o    = pend_q;
    assign drop_cnt_o   = drop_q;
    assign running_o    = (state_q != S_IDLE);
    assign underflow_o  = uf_q;

endmodule

// File: doc/pueo_trig_stamper.md
# pueo_trig_stamper

Trigger admission and timestamp stage in the aclk domain, directly upstream of the event-buffer wrapper's trigger input. It turns raw trigger requests into single-cycle, lookback-corrected buffer timestamps with a running event number. It enforces a per-run trigger holdoff and a cap on outstanding (unread) events, and counts every rejected request.

## Interface
Parameters:
- TIME_BITS, 16, width of timestamp, free-running time counter and holdoff.
- LOOKBACK, 16'd512, aclk cycles subtracted from the request time to form the buffer timestamp.
- MAX_PENDING, 4, maximum outstanding events; legal range 1..15.

Ports (`aclk_i` is the only clock; `aresetn_i` is an asynchronous, active-low reset):
- aclk_i  in  1  sole clock.
- aresetn_i  in  1  asynchronous active-low reset.
- run_rst_i  in  1  run start/restart pulse.
- run_stop_i  in  1  run stop pulse.
- holdoff_i  in  TIME_BITS  holdoff in aclk cycles; captured on run_rst_i.
- trig_req_i  in  1  trigger request, one per cycle high.
- ev_done_i  in  1  pulse when one event finishes readout (frees a slot).
- trig_time_o  out  TIME_BITS  buffer timestamp, valid with trig_valid_o.
- trig_valid_o  out  1  single-cycle strobe per accepted trigger.
- trig_num_o  out  16  event number of the current/last accepted trigger.
- pending_o  out  4  outstanding events.
- drop_cnt_o  out  16  rejected requests this run; saturates at 16'hFFFF.
- running_o  out  1  high in RUN or HOLDOFF.
- underflow_o  out  1  sticky: ev_done_i arrived with pending_o==0.

## Operation
- All outputs reset to 0. State resets to IDLE. The holdoff register resets to 0.
- Time counter `tnow`:
  - Held at 0 in IDLE.
  - Set to 0 on run_rst_i.
  - Otherwise increments by 1 per cycle, wrapping mod 2^TIME_BITS.
- States:
  - IDLE: requests ignored and not counted.
  - RUN: a request with pending_o < MAX_PENDING is accepted. With holdoff 0 the state stays RUN; otherwise it goes to HOLDOFF with the down-counter loaded to holdoff−1.
  - HOLDOFF: every request is dropped. The down-counter decrements each cycle; at 0 the state returns to RUN.
- Priority order: aresetn_i, then run_stop_i, then run_rst_i, then request handling.
- run_stop_i from any state:
  - Goes to IDLE and clears running_o.
  - pending_o and drop_cnt_o hold their values.
  - trig_num_o holds.
- run_rst_i from any state:
  - Goes to RUN and captures holdoff_i.
  - Clears tnow, pending_o, drop_cnt_o, trig_num_o and underflow_o.
  - A request in the same cycle is ignored and not counted.
- Accept:
  - trig_time_o = (tnow at the request cycle − LOOKBACK) mod 2^TIME_BITS.
  - trig_valid_o pulses for one cycle.
  - pending_o increments.
  - trig_num_o takes the pre-increment event count; the first trigger of a run is 0.
  - The internal event counter increments and wraps at 16 bits.
- Drop: a request in RUN with pending full, or any request in HOLDOFF, increments drop_cnt_o (saturating). No strobe is issued.
- Pending count:
  - ev_done_i decrements pending_o, in every state.
  - Accept and ev_done_i in the same cycle leave the count unchanged.
  - A request arriving when the count is full at the start of the cycle is dropped, even if ev_done_i is high in that same cycle.
  - ev_done_i with pending_o == 0 (and no accept) leaves pending_o at 0 and sets underflow_o.

## Timing
- Latency: a request sampled at edge N produces trig_valid_o, trig_time_o and trig_num_o after edge N (registered, 1 cycle). trig_time_o and trig_num_o hold until the next accept.
- Holdoff H: after an accept at cycle N, the next request can be accepted at cycle N+H+1 at the earliest. H=0 allows back-to-back accepts.
- pending_o, drop_cnt_o and running_o update one cycle after their cause.
- run_rst_i and run_stop_i take effect on the sampling edge; outputs reflect the change the next cycle.
- aresetn_i asserted mid-run forces all outputs to 0 immediately (asynchronously). Deassertion is synchronised internally; the first cycle after release is IDLE.
- Timestamp wrap: tnow=5 with LOOKBACK=512 and TIME_BITS=16 gives trig_time_o = 16'hFE05.

## Test plan
- Reset then run_rst_i at cycle 0 (holdoff 0); request at cycle 1000 -> trig_valid_o at 1001, trig_time_o=488, trig_num_o=0, pending_o=1.
- Holdoff 10: requests at cycles 100–115 -> accepts at 100 and 111 only; drop_cnt_o=14.
- MAX_PENDING=4, holdoff 0, six requests in consecutive cycles -> 4 strobes, pending_o=4, drop_cnt_o=2. Then ev_done_i coincident with a request at full -> request dropped, pending_o=3.
- Request at tnow=5 -> trig_time_o=16'hFE05. Then 65536 accepted triggers -> trig_num_o wraps to 0.
- ev_done_i with pending_o=0 -> underflow_o=1, pending_o=0. Then run_rst_i -> underflow_o, drop_cnt_o and trig_num_o all 0.
- Mid-HOLDOFF run_stop_i -> running_o=0 and later requests are uncounted. Then aresetn_i low mid-run -> all outputs 0 asynchronously.
